// File: rtl/e_tx_blk_sched_if.sv
// e_tx_blk_sched_if: host-write, TX FIFO and data-line engine signals of the TX block scheduler
interface e_tx_blk_sched_if;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        buffer_write_en;
  logic        push;
  logic [15:0] push_data;
  logic        fifo_sel_l;
  logic        fifo_sel_h;
  logic        dat_end;
  logic        xfer_start;
  logic        xfer_done;
  logic        crc_err;
  modport master (
    output wr_valid, wr_data, buffer_write_en, xfer_done, crc_err,
    input  wr_ready, push, push_data, fifo_sel_l, fifo_sel_h, dat_end, xfer_start
  );
  modport slave (
    input  wr_valid, wr_data, buffer_write_en, xfer_done, crc_err,
    output wr_ready, push, push_data, fifo_sel_l, fifo_sel_h, dat_end, xfer_start
  );
endinterface

// File: rtl/e_tx_blk_sched.sv
// e_tx_blk_sched: SDIO host-write block scheduler; E_TX_BLK_SCHED_TIMEOUT_EN adds a WAIT_DONE watchdog and timeout_flag
module e_tx_blk_sched #(
  parameter int BLK_CNT_W      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [11:0]          block_size_reg,
  input  logic [BLK_CNT_W-1:0] block_count_reg,
  e_tx_blk_sched_if.slave      bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [BLK_CNT_W-1:0] blocks_left
`ifdef E_TX_BLK_SCHED_TIMEOUT_EN
  ,
  output logic                 timeout_flag
`endif
);
  typedef enum logic [2:0] {IDLE, FILL_LO, FILL_HI, SEND, WAIT_DONE, FLUSH} state_t;
  state_t state, nxt;
  logic [11:0] byte_cnt, bc_d, rem;
  logic [15:0] hi_q, hi_d, d_data;
  logic [BLK_CNT_W-1:0] bl_d;
  logic d_push, d_l, d_h, d_end, d_xs, d_done, err_d, acc;
  logic gi_q, gi_d, ok_q, ok_d;
`ifdef E_TX_BLK_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic to_d, to_hit;
  assign to_hit = to_cnt == 16'(TIMEOUT_CYCLES - 1);
`endif
  assign bus.wr_ready = (state == FILL_LO) & bus.buffer_write_en & ~abort;
  assign busy = state != IDLE;
  assign acc = bus.wr_valid & bus.wr_ready;
  assign rem = block_size_reg - byte_cnt;
  // next state and next values of every registered output; gi_q marks a FLUSH that ends the transfer, ok_q a successful one
  always_comb begin
    nxt = state;
    bc_d = byte_cnt;
    hi_d = hi_q;
    bl_d = blocks_left;
    err_d = err;
    gi_d = gi_q;
    ok_d = ok_q;
    d_push = 1'b0;
    d_data = bus.push_data;
    d_l = 1'b0;
    d_h = 1'b0;
    d_end = 1'b0;
    d_xs = 1'b0;
    d_done = 1'b0;
`ifdef E_TX_BLK_SCHED_TIMEOUT_EN
    to_d = timeout_flag;
`endif
    case (state)
      IDLE: if (start) begin
        if (block_size_reg != '0 && block_count_reg != '0) begin
          nxt = FILL_LO;
          bl_d = block_count_reg;
          bc_d = '0;
          err_d = 1'b0;
          gi_d = 1'b0;
          ok_d = 1'b0;
`ifdef E_TX_BLK_SCHED_TIMEOUT_EN
          to_d = 1'b0;
`endif
        end else err_d = 1'b1;
      end
      FILL_LO: if (acc) begin
        d_push = 1'b1;
        d_data = bus.wr_data[15:0];
        d_l = 1'b1;
        hi_d = bus.wr_data[31:16];
        bc_d = rem <= 12'd2 ? block_size_reg : byte_cnt;
        nxt = rem <= 12'd2 ? SEND : FILL_HI;
      end
      FILL_HI: begin
        d_push = 1'b1;
        d_data = hi_q;
        d_h = 1'b1;
        bc_d = rem <= 12'd4 ? block_size_reg : byte_cnt + 12'd4;
        nxt = rem <= 12'd4 ? SEND : FILL_LO;
      end
      SEND: begin
        d_xs = 1'b1;
        nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.xfer_done) begin
          nxt = FLUSH;
          if (bus.crc_err) begin
            err_d = 1'b1;
            gi_d = 1'b1;
            ok_d = 1'b0;
          end else begin
            bl_d = blocks_left != '0 ? blocks_left - BLK_CNT_W'(1) : blocks_left;
            gi_d = blocks_left <= BLK_CNT_W'(1);
            ok_d = blocks_left <= BLK_CNT_W'(1);
          end
        end
`ifdef E_TX_BLK_SCHED_TIMEOUT_EN
        else if (to_hit) begin
          nxt = FLUSH;
          err_d = 1'b1;
          to_d = 1'b1;
          gi_d = 1'b1;
          ok_d = 1'b0;
        end
`endif
      end
      FLUSH: begin
        d_end = 1'b1;
        d_done = ok_q;
        bc_d = '0;
        nxt = gi_q ? IDLE : FILL_LO;
      end
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      nxt = state == FLUSH ? IDLE : FLUSH;
      d_push = 1'b0;
      d_data = bus.push_data;
      d_l = 1'b0;
      d_h = 1'b0;
      d_xs = 1'b0;
      d_done = 1'b0;
      hi_d = hi_q;
      bl_d = blocks_left;
      err_d = err;
      gi_d = 1'b1;
      ok_d = 1'b0;
`ifdef E_TX_BLK_SCHED_TIMEOUT_EN
      to_d = timeout_flag;
`endif
    end
  end
  // state, bookkeeping and registered outputs
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      byte_cnt <= '0;
      hi_q <= '0;
      blocks_left <= '0;
      err <= 1'b0;
      gi_q <= 1'b0;
      ok_q <= 1'b0;
      bus.push <= 1'b0;
      bus.push_data <= '0;
      bus.fifo_sel_l <= 1'b0;
      bus.fifo_sel_h <= 1'b0;
      bus.dat_end <= 1'b0;
      bus.xfer_start <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      byte_cnt <= bc_d;
      hi_q <= hi_d;
      blocks_left <= bl_d;
      err <= err_d;
      gi_q <= gi_d;
      ok_q <= ok_d;
      bus.push <= d_push;
      bus.push_data <= d_data;
      bus.fifo_sel_l <= d_l;
      bus.fifo_sel_h <= d_h;
      bus.dat_end <= d_end;
      bus.xfer_start <= d_xs;
      done <= d_done;
    end
`ifdef E_TX_BLK_SCHED_TIMEOUT_EN
  // watchdog counts only while waiting for the engine, so it restarts at zero on every WAIT_DONE entry
  always_ff @(posedge clk)
    if (rst) begin
      to_cnt <= '0;
      timeout_flag <= 1'b0;
    end else begin
      to_cnt <= state == WAIT_DONE ? to_cnt + 16'd1 : '0;
      timeout_flag <= to_d;
    end
`endif
endmodule

// File: tb/tb_e_tx_blk_sched.sv
// tb_e_tx_blk_sched: directed checks of the TX block scheduler
module tb_e_tx_blk_sched;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [11:0] bsz = '0;
  logic [15:0] bcnt = '0;
  logic busy, done, err;
  logic [15:0] blocks_left;
`ifdef E_TX_BLK_SCHED_TIMEOUT_EN
  logic timeout_flag;
`endif
  e_tx_blk_sched_if bus ();
  e_tx_blk_sched #(.BLK_CNT_W(16), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .block_size_reg(bsz),
    .block_count_reg(bcnt),
    .bus(bus),
    .busy(busy),
    .done(done),
    .err(err),
    .blocks_left(blocks_left)
`ifdef E_TX_BLK_SCHED_TIMEOUT_EN
    ,
    .timeout_flag(timeout_flag)
`endif
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int cyc = 0, wp = 0, pcyc = 0, xcyc = 0, n_end = 0, n_xs = 0, n_done = 0;
  int b, e, d, x;
  logic [17:0] plog [0:63];
  // log every push as {sel_h, sel_l, data} and count strobes, away from the active edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.push) begin
      plog[wp[5:0]] <= {bus.fifo_sel_h, bus.fifo_sel_l, bus.push_data};
      wp <= wp + 1;
      pcyc <= cyc;
    end
    if (bus.dat_end) n_end <= n_end + 1;
    if (bus.xfer_start) begin
      n_xs <= n_xs + 1;
      xcyc <= cyc;
    end
    if (done) n_done <= n_done + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [11:0] sz, input logic [15:0] cnt);
    bsz = sz;
    bcnt = cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    bus.wr_valid = 1'b1;
    bus.wr_data = w;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.wr_ready) break;
    end
    chk("wr_accept", bus.wr_ready, 1);
    tick();
    bus.wr_valid = 1'b0;
  endtask
  task automatic wait_xs();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.xfer_start) break;
    end
    chk("xs_seen", bus.xfer_start, 1);
  endtask
  task automatic xdone(input logic c);
    bus.xfer_done = 1'b1;
    bus.crc_err = c;
    tick();
    bus.xfer_done = 1'b0;
    bus.crc_err = 1'b0;
  endtask
  task automatic snap();
    b = wp;
    e = n_end;
    d = n_done;
    x = n_xs;
  endtask
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.buffer_write_en = 1'b1;
    bus.xfer_done = 1'b0;
    bus.crc_err = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_bl", blocks_left, 0);
    chk("rst_push", bus.push, 0);
    chk("rst_end", bus.dat_end, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", bus.wr_ready, 0);
    rst = 1'b0;
    tick();
    snap();
    go(12'd8, 16'd1);
    chk("t1_ready", bus.wr_ready, 1);
    chk("t1_bl", blocks_left, 1);
    send_word(32'h44332211);
    send_word(32'h88776655);
    wait_xs();
    chk("t1_npush", wp - b, 4);
    chk("t1_p0", plog[b], {2'b01, 16'h2211});
    chk("t1_p1", plog[b+1], {2'b10, 16'h4433});
    chk("t1_p2", plog[b+2], {2'b01, 16'h6655});
    chk("t1_p3", plog[b+3], {2'b10, 16'h8877});
    xdone(1'b0);
    repeat (3) tick();
    chk("t1_end", n_end - e, 1);
    chk("t1_done", n_done - d, 1);
    chk("t1_bl0", blocks_left, 0);
    chk("t1_busy", busy, 0);
    snap();
    go(12'd6, 16'd1);
    bus.buffer_write_en = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data = 32'h44332211;
    repeat (3) tick();
    chk("bwe_ready", bus.wr_ready, 0);
    chk("bwe_push", wp - b, 0);
    bus.buffer_write_en = 1'b1;
    send_word(32'h44332211);
    send_word(32'h88776655);
    wait_xs();
    xdone(1'b0);
    repeat (3) tick();
    chk("t2_npush", wp - b, 3);
    chk("t2_p2", plog[b+2], {2'b01, 16'h6655});
    chk("t2_xs_lat", xcyc - pcyc, 1);
    chk("t2_done", n_done - d, 1);
    snap();
    go(12'd4, 16'd3);
    for (int i = 0; i < 3; i++) begin
      send_word(32'hC0DE0000 + i);
      wait_xs();
      xdone(1'b0);
      repeat (3) tick();
      chk("t3_bl", blocks_left, 2 - i);
      chk("t3_done", n_done - d, (i == 2) ? 1 : 0);
    end
    chk("t3_xs", n_xs - x, 3);
    chk("t3_end", n_end - e, 3);
    chk("t3_npush", wp - b, 6);
    snap();
    go(12'd4, 16'd3);
    send_word(32'h12345678);
    wait_xs();
    xdone(1'b0);
    repeat (3) tick();
    send_word(32'h9abcdef0);
    wait_xs();
    xdone(1'b1);
    repeat (3) tick();
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_bl", blocks_left, 2);
    chk("t4_end", n_end - e, 2);
    chk("t4_done", n_done - d, 0);
    go(12'd8, 16'd1);
    chk("t5_errclr", err, 0);
    snap();
    send_word(32'h11112222);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    chk("t5a_npush", wp - b, 1);
    chk("t5a_end", n_end - e, 1);
    chk("t5a_busy", busy, 0);
    chk("t5a_err", err, 0);
    chk("t5a_done", n_done - d, 0);
    snap();
    go(12'd4, 16'd1);
    send_word(32'h33334444);
    wait_xs();
    abort = 1'b1;
    bus.xfer_done = 1'b1;
    tick();
    abort = 1'b0;
    bus.xfer_done = 1'b0;
    repeat (3) tick();
    chk("t5b_end", n_end - e, 1);
    chk("t5b_done", n_done - d, 0);
    chk("t5b_err", err, 0);
    chk("t5b_busy", busy, 0);
    chk("t5b_bl", blocks_left, 1);
    snap();
    go(12'd4, 16'd0);
    repeat (2) tick();
    chk("cnt0_err", err, 1);
    chk("cnt0_busy", busy, 0);
    chk("cnt0_end", n_end - e, 0);
    go(12'd4, 16'd1);
    chk("sz0_pre", err, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();
    go(12'd0, 16'd1);
    repeat (2) tick();
    chk("sz0_err", err, 1);
    chk("sz0_busy", busy, 0);
`ifdef E_TX_BLK_SCHED_TIMEOUT_EN
    go(12'd4, 16'd1);
    chk("to_clr", timeout_flag, 0);
    snap();
    send_word(32'h55556666);
    wait_xs();
    begin
      int n;
      n = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        n++;
        if (err) break;
      end
      chk("to_cycles", n, 20);
    end
    chk("to_flag", timeout_flag, 1);
    repeat (3) tick();
    chk("to_end", n_end - e, 1);
    chk("to_busy", busy, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/e_tx_blk_sched.md
Name: e_tx_blk_sched

Overview:
- Transmit block scheduler for the SDIO host write path.
- Accepts 32-bit host write words and splits each into 16-bit halves pushed into the TX FIFO with fifo_sel_l/fifo_sel_h.
- Sequences the data-line engine once per block, then pulses dat_end to reset the FIFO between blocks; repeats until block_count blocks are sent, abort is asserted, or an error occurs.
- Sits between the host register/DMA interface and the TX FIFO and data-line engine, all in the clk domain.

Parameters:
- BLK_CNT_W, 16, width of block count and blocks_left.
- TIMEOUT_CYCLES, 65535, WAIT_DONE watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a transfer; sampled only in IDLE.
- abort  in  1  level; terminates the transfer.
- block_size_reg  in  12  bytes per block, 1..2048.
- block_count_reg  in  BLK_CNT_W  number of blocks, at least 1.
- wr_valid  in  1  host word valid.
- wr_data  in  32  host word; bytes little-endian.
- wr_ready  out  1  host word accepted when wr_valid & wr_ready.
- buffer_write_en  in  1  FIFO can take data for the current block.
- push  out  1  FIFO push strobe.
- push_data  out  16  FIFO write data.
- fifo_sel_l  out  1  low half is being pushed.
- fifo_sel_h  out  1  high half is being pushed.
- dat_end  out  1  one-cycle FIFO/block reset pulse.
- xfer_start  out  1  one-cycle pulse to the data-line engine.
- xfer_done  in  1  one-cycle pulse: block sent and CRC status received.
- crc_err  in  1  qualifies xfer_done.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error; cleared by the next accepted start or by rst.
- blocks_left  out  BLK_CNT_W  blocks not yet completed.

Behaviour:
- Reset, synchronous active-high: state=IDLE; all outputs 0 including err and blocks_left; byte_cnt=0.
- Registered outputs: push, push_data, fifo_sel_l, fifo_sel_h, dat_end, xfer_start, done.
- Combinational output: wr_ready = (state==FILL_LO) & buffer_write_en & ~abort.
- States: IDLE, FILL_LO, FILL_HI, SEND, WAIT_DONE, FLUSH.
- IDLE:
  - start with block_size_reg!=0 and block_count_reg!=0: load blocks_left=block_count_reg, byte_cnt=0, clear err, go to FILL_LO. wr_ready is high the next cycle.
  - start with either value 0: err=1 for that case, stay in IDLE, no dat_end.
- FILL_LO, on accept:
  - Next cycle: push=1, push_data=wr_data[15:0], fifo_sel_l=1; latch wr_data[31:16].
  - If block_size_reg-byte_cnt <= 2: byte_cnt=block_size_reg, go to SEND and skip the high push.
  - Otherwise go to FILL_HI.
- FILL_HI:
  - push=1, push_data=latched high half, fifo_sel_h=1.
  - byte_cnt += min(4, remaining); remaining = block_size_reg - byte_cnt as of the preceding FILL_LO.
  - If byte_cnt then reaches block_size_reg, go to SEND; else go to FILL_LO.
  - Back-to-back words are therefore accepted at most every 2 cycles.
- buffer_write_en low in FILL_LO: wait with wr_ready=0; no pushes while it is low.
- SEND: xfer_start=1 for one cycle, then WAIT_DONE.
- WAIT_DONE, on xfer_done:
  - crc_err=1: err=1, go to FLUSH, then IDLE.
  - crc_err=0: blocks_left--. If the result is 0, go to FLUSH and then IDLE with done=1 in the FLUSH-exit cycle. Otherwise go to FLUSH, then FILL_LO with byte_cnt=0.
- FLUSH: dat_end=1 for exactly one cycle.
- abort:
  - Asserted in any non-IDLE state: next state FLUSH, giving one dat_end, then IDLE.
  - No done pulse; err unchanged.
  - Any push in flight in that cycle is suppressed.
  - abort has priority over xfer_done in the same cycle.
- start while busy is ignored.
- byte_cnt is 12 bits and never exceeds block_size_reg. blocks_left does not wrap.

Optional Feature:
- Macro: E_TX_BLK_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_DONE and increments every cycle while in WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES without xfer_done: err=1, go to FLUSH, then IDLE.
  - Extra output timeout_flag: sticky, cleared like err.
- Undefined: no counter and no timeout_flag port; WAIT_DONE waits indefinitely.

Test Plan:
- Single block, block_size_reg=8, count=1, start, words 0x44332211 then 0x88776655 → pushes 0x2211/l, 0x4433/h, 0x6655/l, 0x8877/h; then xfer_start; xfer_done with crc_err=0 → dat_end pulse, done pulse, blocks_left=0, busy low.
- Odd size, block_size_reg=6 → exactly 3 pushes, the third 0x6655 with fifo_sel_l; second word's high half is dropped; xfer_start one cycle after the third push.
- Multi-block, size=4, count=3 → 3 xfer_start and 3 dat_end pulses; blocks_left steps 3→2→1→0; done pulse only after the third block.
- crc_err=1 on the 2nd xfer_done of a count=3 transfer → err=1, one dat_end, IDLE, blocks_left=2, no done pulse.
- abort in FILL_HI, and separately in WAIT_DONE → no push in the abort cycle, one dat_end, IDLE, err=0; then start with count=0 → err=1, busy stays 0.
- E_TX_BLK_SCHED_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, xfer_done withheld → err=1 and timeout_flag=1 at the 20th WAIT_DONE cycle, one dat_end, IDLE.
